max31855_read_scheduler: RTL
============================

// Module: max31855_read_scheduler
// PURPOSE
//  Sequences periodic and on-demand reads of the MAX31855 thermocouple converter.
//  Drives the 32-bit SPI master through a start/done handshake, then checks the frame.
//  Retries on faulted or stuck frames and splits each frame into its temperature fields.
//  Presents one sample per read on a valid/ready port that feeds the UART formatter.
// PARAMETERS
//  PERIOD_CYCLES   10_000_000  clk_i cycles between automatic reads (100 ms @ 100 MHz); >= 2
//  TIMEOUT_CYCLES  4096        max cycles from spi_start to spi_done before a timeout
//  MAX_RETRY       3           extra reads after a bad frame (0 = no retry)
// PORTS
//  clk_i        in   1   system clock; every register is on its rising edge
//  reset        in   1   asynchronous reset, active-high
//  enable       in   1   1 = period timer runs; 0 = timer held at 0
//  trigger      in   1   one-cycle pulse: request an immediate read
//  spi_start    out  1   one-cycle pulse to the SPI master: begin a 32-bit frame
//  spi_done     in   1   one-cycle pulse from the SPI master: frame complete
//  spi_frame    in   32  frame from the SPI master; valid in the spi_done cycle
//  busy         out  1   1 in any state except WAIT
//  out_valid    out  1   sample available; held until accepted
//  out_ready    in   1   sink accepts the sample when out_valid && out_ready
//  tc_temp      out  14  thermocouple temperature, frame[31:18], signed, 0.25 C/LSB
//  cj_temp      out  12  cold-junction temperature, frame[15:4], signed, 0.0625 C/LSB
//  status       out  6   {overrun, timeout, stuck, scv, scg, oc}
// BEHAVIOUR
//  Reset: state=WAIT, timer=0, retry=0, pend=0; every output is 0.
//   A spi_done that arrives after reset while in WAIT is ignored.
//  Request flag pend:
//   - set by trigger, or by timer==PERIOD_CYCLES-1 while enable=1; the timer then wraps to 0
//   - cleared on leaving WAIT; a trigger or tick while busy=1 leaves pend=1
//   - at most one read is queued; further requests collapse into it
//  States:
//   WAIT : if pend -> START (retry=0)
//   START: spi_start=1 for exactly one cycle; tmo=0 -> XFER
//   XFER : on spi_done, latch spi_frame -> CHECK
//          else if tmo==TIMEOUT_CYCLES-1 -> PUB with timeout=1
//          tmo increments every cycle in XFER
//   CHECK: bad = frame[16] | frame==32'h0 | frame==32'hFFFF_FFFF
//          if bad && retry<MAX_RETRY: retry++ -> START
//          else -> PUB
//   PUB  : load tc_temp, cj_temp and status; out_valid=1 -> WAIT
//  Status bits:
//   - stuck = frame all-0 or all-1; {scv,scg,oc} = frame[2:0]
//   - on timeout: tc_temp and cj_temp keep their previous values; stuck/scv/scg/oc=0
//  Latency: spi_done to out_valid high = 2 cycles (CHECK, then PUB).
//  Output handshake:
//   - out_valid clears on the cycle after out_valid && out_ready
//   - if PUB runs while out_valid=1 and out_ready=0: fields are overwritten, out_valid stays 1,
//     overrun=1 for that sample
//   - PUB and acceptance in the same cycle: the new sample wins, out_valid stays 1, overrun=0
//  Arithmetic:
//   - timer and tmo are $clog2 of their limit in width; they never exceed the limit
//   - fields are raw bit slices; no scaling or sign extension
//  enable falling mid-read does not abort the read; only pend generation stops.
// TESTING  (PERIOD_CYCLES=100, TIMEOUT_CYCLES=50, MAX_RETRY=2)
//  1. reset mid-XFER -> all outputs 0 and state WAIT in the same cycle;
//     a later spi_done produces no out_valid.
//  2. enable=1, frame 32'h0640_1900, done 10 cycles after start, out_ready=1 ->
//     tc_temp=14'h0190, cj_temp=12'h190, status=0;
//     spi_start repeats every 100 cycles.
//  3. trigger, frame 32'hFFFC_FFF0 -> tc_temp=14'h3FFF, cj_temp=12'hFFF, status=0.
//  4. trigger, first frame 32'h0001_0001, second 32'h0640_1900 -> 2 spi_start pulses,
//     one out_valid, status=0.
//     Same test with 32'h0001_0001 three times -> 3 starts, then status=6'b000001.
//  5. trigger, spi_done never asserted -> out_valid exactly 51 cycles after spi_start,
//     status=6'b010000.
//  6. out_ready=0 for 2 periods -> second sample has status[5]=1;
//     trigger while busy -> exactly one extra spi_start after the current read.

Source files
------------

// File: rtl/max31855_read_scheduler_if.sv
// Handshake bundle between the MAX31855 read scheduler, the SPI master and the sample sink.
// master = scheduler side, slave = SPI master / sink / control side.
interface max31855_read_scheduler_if;
  logic        enable;
  logic        trigger;
  logic        spi_start;
  logic        spi_done;
  logic [31:0] spi_frame;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] tc_temp;
  logic [11:0] cj_temp;
  logic [5:0]  status;

  modport master (
    input  enable, trigger, spi_done, spi_frame, out_ready,
    output spi_start, busy, out_valid, tc_temp, cj_temp, status
  );

  modport slave (
    output enable, trigger, spi_done, spi_frame, out_ready,
    input  spi_start, busy, out_valid, tc_temp, cj_temp, status
  );
endinterface

// File: rtl/max31855_read_scheduler.sv
// Periodic / on-demand MAX31855 frame reader with retry, timeout and a held output sample.
//   state   | meaning
//   S_WAIT  | idle, start a read when a request is pending
//   S_START | one-cycle spi_start pulse, clear timeout counter
//   S_XFER  | wait for spi_done or timeout
//   S_CHECK | judge frame, retry or publish
//   S_PUB   | sample just published, return to idle
module max31855_read_scheduler #(
  parameter int PERIOD_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3
) (
  input logic                        clk_i,
  input logic                        reset,
  max31855_read_scheduler_if.master  bus
);
  localparam int TW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int MW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYCLES - 1);
  localparam logic [MW-1:0] TMO_LAST   = MW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_WAIT, S_START, S_XFER, S_CHECK, S_PUB} state_e;

  state_e      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [MW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        pend_q, pend_d;
  logic [31:0] frame_q, frame_d;
  logic        out_valid_q, out_valid_d;
  logic [13:0] tc_q, tc_d;
  logic [11:0] cj_q, cj_d;
  logic [5:0]  status_q, status_d;

  logic tick, stuck, frame_bad, load, load_tmo, overrun;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT;
      timer_q     <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      pend_q      <= 1'b0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      tc_q        <= '0;
      cj_q        <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
      tc_q        <= tc_d;
      cj_q        <= cj_d;
      status_q    <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    pend_d      = pend_q;
    frame_d     = frame_q;
    out_valid_d = out_valid_q;
    tc_d        = tc_q;
    cj_d        = cj_q;
    status_d    = status_q;
    tick        = 1'b0;
    load        = 1'b0;
    load_tmo    = 1'b0;
    stuck       = (frame_q == 32'h0) | (&frame_q);
    frame_bad   = frame_q[16] | stuck;
    overrun     = out_valid_q & ~bus.out_ready;

    if (bus.enable) begin
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        tick    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end

    case (state_q)
      S_WAIT: begin
        if (pend_q) begin
          state_d = S_START;
          retry_d = '0;
          pend_d  = 1'b0;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (bus.spi_done) begin
          frame_d = bus.spi_frame;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_PUB;
          load     = 1'b1;
          load_tmo = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (frame_bad && (retry_q < RETRY_MAX)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_PUB;
          load    = 1'b1;
        end
      end
      S_PUB:   state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase

    // A request arriving on the very cycle WAIT is left still queues one more read.
    if (bus.trigger || tick) pend_d = 1'b1;

    // The sample is loaded on the edge entering PUB so out_valid is high during PUB.
    if (load) begin
      out_valid_d = 1'b1;
      if (load_tmo) begin
        status_d = {overrun, 1'b1, 4'b0000};
      end else begin
        tc_d     = frame_q[31:18];
        cj_d     = frame_q[15:4];
        status_d = {overrun, 1'b0, stuck, frame_q[2:0]};
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign bus.spi_start = (state_q == S_START);
  assign bus.busy      = (state_q != S_WAIT);
  assign bus.out_valid = out_valid_q;
  assign bus.tc_temp   = tc_q;
  assign bus.cj_temp   = cj_q;
  assign bus.status    = status_q;
endmodule
